// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit bus to 16-bit asynchronous SRAM controller with registered strobes
module sram_controller #(
    parameter int ADDR_WIDTH    = 18,
    parameter int ACCESS_CYCLES = 3
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_request,
    input  logic                  i_rw,
    input  logic [31:0]           i_address,
    input  logic [31:0]           i_wdata,
    input  logic [3:0]            i_wmask,
    output logic [31:0]           o_rdata,
    output logic                  o_ready,
    output logic [ADDR_WIDTH-1:0] SRAM_A,
    inout  wire  [15:0]           SRAM_D,
    output logic                  SRAM_CE_n,
    output logic                  SRAM_OE_n,
    output logic                  SRAM_WE_n,
    output logic                  SRAM_LB_n,
    output logic                  SRAM_UB_n
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, RELEASE} state_t;

    localparam logic [3:0] LAST_CYC = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] WE_END   = 4'(ACCESS_CYCLES - 2);

    state_t                state, state_n;
    logic                  beat, beat_n;
    logic [3:0]            cyc, cyc_n;
    logic                  rw_q;
    logic [ADDR_WIDTH-2:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wmask_q;

    logic                  accept;
    logic                  rw_v;
    logic [ADDR_WIDTH-2:0] addr_v;
    logic [31:0]           wdata_v;
    logic [3:0]            wmask_v;

    logic                  d_oe, d_oe_n;
    logic [15:0]           d_out, d_out_n;
    logic                  ce_n_n, oe_n_n, we_n_n, lb_n_n, ub_n_n, ready_n;
    logic [ADDR_WIDTH-1:0] a_n;
    logic [31:0]           rdata_n;

    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{i_address[31:ADDR_WIDTH+1], i_address[1:0]};

    // Outputs are computed from the values that will hold after the edge, so the
    // acceptance edge already presents the first beat on the pins.
    assign accept  = (state == IDLE) && i_request;
    assign rw_v    = accept ? i_rw : rw_q;
    assign addr_v  = accept ? i_address[ADDR_WIDTH:2] : addr_q;
    assign wdata_v = accept ? i_wdata : wdata_q;
    assign wmask_v = accept ? i_wmask : wmask_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= IDLE;
            beat    <= 1'b0;
            cyc     <= 4'd0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
            cyc   <= cyc_n;
            if (accept) begin
                rw_q    <= i_rw;
                addr_q  <= i_address[ADDR_WIDTH:2];
                wdata_q <= i_wdata;
                wmask_q <= i_wmask;
            end
        end
    end

    always_comb begin
        state_n = state;
        beat_n  = beat;
        cyc_n   = cyc;
        case (state)
            IDLE: begin
                if (i_request) begin
                    cyc_n = 4'd0;
                    if (!i_rw || (i_wmask[1:0] != 2'b00)) begin
                        state_n = ACCESS;
                        beat_n  = 1'b0;
                    end else if (i_wmask[3:2] != 2'b00) begin
                        state_n = ACCESS;
                        beat_n  = 1'b1;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            ACCESS: begin
                if (!i_request) begin
                    state_n = IDLE;
                end else if (cyc == LAST_CYC) begin
                    cyc_n = 4'd0;
                    if (beat || (rw_q && (wmask_q[3:2] == 2'b00))) state_n = DONE;
                    else beat_n = 1'b1;
                end else begin
                    cyc_n = cyc + 4'd1;
                end
            end
            DONE:    state_n = RELEASE;
            RELEASE: if (!i_request) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ce_n_n  = 1'b1;
        oe_n_n  = 1'b1;
        we_n_n  = 1'b1;
        lb_n_n  = 1'b1;
        ub_n_n  = 1'b1;
        d_oe_n  = 1'b0;
        d_out_n = d_out;
        a_n     = SRAM_A;
        rdata_n = o_rdata;
        ready_n = (state_n == DONE);
        if (state_n == ACCESS) begin
            ce_n_n = 1'b0;
            a_n    = {addr_v, beat_n};
            if (rw_v) begin
                // WE_n stays high on the first and last beat cycle for setup/hold margin.
                we_n_n  = !((cyc_n >= 4'd1) && (cyc_n <= WE_END));
                lb_n_n  = ~wmask_v[{beat_n, 1'b0}];
                ub_n_n  = ~wmask_v[{beat_n, 1'b1}];
                d_oe_n  = 1'b1;
                d_out_n = beat_n ? wdata_v[31:16] : wdata_v[15:0];
            end else begin
                oe_n_n = 1'b0;
                lb_n_n = 1'b0;
                ub_n_n = 1'b0;
            end
        end
        if ((state == ACCESS) && i_request && !rw_q && (cyc == LAST_CYC)) begin
            if (beat) rdata_n[31:16] = SRAM_D;
            else      rdata_n[15:0]  = SRAM_D;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            SRAM_CE_n <= 1'b1;
            SRAM_OE_n <= 1'b1;
            SRAM_WE_n <= 1'b1;
            SRAM_LB_n <= 1'b1;
            SRAM_UB_n <= 1'b1;
            SRAM_A    <= '0;
            d_oe      <= 1'b0;
            d_out     <= '0;
            o_rdata   <= '0;
            o_ready   <= 1'b0;
        end else begin
            SRAM_CE_n <= ce_n_n;
            SRAM_OE_n <= oe_n_n;
            SRAM_WE_n <= we_n_n;
            SRAM_LB_n <= lb_n_n;
            SRAM_UB_n <= ub_n_n;
            SRAM_A    <= a_n;
            d_oe      <= d_oe_n;
            d_out     <= d_out_n;
            o_rdata   <= rdata_n;
            o_ready   <= ready_n;
        end
    end

    assign SRAM_D = d_oe ? d_out : 16'bz;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - randomized bench for sram_controller against a word-level memory model
module tb_sram_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0, req5 = 1'b0, rw = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  wmask = '0;
    logic [31:0] rdata, rdata5;
    logic        ready, ready5;
    logic [17:0] sa, sa5;
    tri1  [15:0] sd;
    tri1  [15:0] sd5;
    logic        ce_n, oe_n, we_n, lb_n, ub_n;
    logic        ce5, oe5, we5, lb5, ub5;
    logic [4:0]  strobes;
    assign strobes = {ce_n, oe_n, we_n, lb_n, ub_n};

    int pass_cnt = 0;
    int total    = 0;

    sram_controller #(.ADDR_WIDTH(18), .ACCESS_CYCLES(3)) dut3 (
        .i_clock(clk), .i_reset_n(rst_n), .i_request(req), .i_rw(rw), .i_address(addr),
        .i_wdata(wdata), .i_wmask(wmask), .o_rdata(rdata), .o_ready(ready), .SRAM_A(sa),
        .SRAM_D(sd), .SRAM_CE_n(ce_n), .SRAM_OE_n(oe_n), .SRAM_WE_n(we_n),
        .SRAM_LB_n(lb_n), .SRAM_UB_n(ub_n));

    sram_controller #(.ADDR_WIDTH(18), .ACCESS_CYCLES(5)) dut5 (
        .i_clock(clk), .i_reset_n(rst_n), .i_request(req5), .i_rw(rw), .i_address(addr),
        .i_wdata(wdata), .i_wmask(wmask), .o_rdata(rdata5), .o_ready(ready5), .SRAM_A(sa5),
        .SRAM_D(sd5), .SRAM_CE_n(ce5), .SRAM_OE_n(oe5), .SRAM_WE_n(we5),
        .SRAM_LB_n(lb5), .SRAM_UB_n(ub5));

    always #5 clk = ~clk;

    // Physical SRAM for the 3-cycle instance; the 5-cycle instance sees a fixed address pattern.
    logic [15:0] mem [0:262143];
    assign sd  = (!ce_n && !oe_n && we_n) ? mem[sa] : 16'hzzzz;
    assign sd5 = (!ce5 && !oe5) ? (sa5[15:0] ^ 16'h5A3C) : 16'hzzzz;

    int          cyc_cnt = 0;
    int          oe_cnt  = 0;
    int          we_cyc[$];
    logic [17:0] we_addr[$];
    logic [15:0] we_data[$];
    logic [1:0]  we_be[$];

    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (!ce_n && !we_n) begin
            we_cyc.push_back(cyc_cnt);
            we_addr.push_back(sa);
            we_data.push_back(sd);
            we_be.push_back({ub_n, lb_n});
            if (!lb_n) mem[sa][7:0]  <= sd[7:0];
            if (!ub_n) mem[sa][15:8] <= sd[15:8];
        end
        if (!ce_n && !oe_n) oe_cnt <= oe_cnt + 1;
    end

    logic [15:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] hw(input logic [31:0] a, input int b);
        return (((a >> 2) & 32'h1FFFF) << 1) | 32'(b);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [31:0] i);
        return ref_mem.exists(i) ? ref_mem[i] : 16'h0000;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return {ref_rd(hw(a, 1)), ref_rd(hw(a, 0))};
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] i;
        logic [15:0] v;
        for (int b = 0; b < 2; b++) begin
            i = hw(a, b);
            v = ref_rd(i);
            if (m[2*b])   v[7:0]  = d[16*b +: 8];
            if (m[2*b+1]) v[15:8] = d[16*b+8 +: 8];
            ref_mem[i] = v;
        end
    endfunction

    function automatic int exp_lat(input logic t_rw, input logic [3:0] m, input int ac);
        int n;
        n = t_rw ? (int'(m[1:0] != 2'b00) + int'(m[3:2] != 2'b00)) : 2;
        return 1 + n * ac;
    endfunction

    task automatic run_txn(input logic t_rw, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                           input logic [3:0] t_mask, output int lat, output logic [31:0] got,
                           output int t0, output logic [15:0] d_rdy);
        repeat (2) @(negedge clk);
        req = 1'b1; rw = t_rw; addr = t_addr; wdata = t_wdata; wmask = t_mask;
        @(posedge clk);
        #1;
        rw = 1'($urandom); addr = $urandom; wdata = $urandom; wmask = 4'($urandom);
        lat = -1; got = '0; t0 = 0; d_rdy = '0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (i == 1) t0 = cyc_cnt;
            if (ready) begin
                lat = i; got = rdata; d_rdy = sd;
                break;
            end
        end
        req = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (strobes !== 5'h1F) $display("FAIL reset_strobes: got %b want 11111", strobes); else pass_cnt++;
        total++; if (sa !== 18'h0) $display("FAIL reset_addr: got %h want 0", sa); else pass_cnt++;
        total++; if (sd !== 16'hFFFF) $display("FAIL reset_bus_released: got %h want ffff", sd); else pass_cnt++;
        total++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else pass_cnt++;
        total++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else pass_cnt++;
        total++;
        if ({ce5, oe5, we5, lb5, ub5, ready5} !== 6'b111110 || sa5 !== 18'h0)
            $display("FAIL reset_dut5: got %b/%h want 111110/0", {ce5, oe5, we5, lb5, ub5, ready5}, sa5);
        else pass_cnt++;
    endtask

    task automatic test_write_full();
        int lat, t0, w0;
        logic [31:0] got;
        logic [15:0] d;
        w0 = we_cyc.size();
        run_txn(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, lat, got, t0, d);
        model_write(32'h0000_0010, 32'hDEADBEEF, 4'hF);
        total++; if (lat !== 7) $display("FAIL wr_full_lat: got %0d want 7", lat); else pass_cnt++;
        total++; if (we_cyc.size() - w0 !== 2) $display("FAIL wr_full_pulses: got %0d want 2", we_cyc.size() - w0); else pass_cnt++;
        if (we_cyc.size() - w0 == 2) begin
            total++; if (we_addr[w0] !== 18'd8 || we_addr[w0+1] !== 18'd9)
                $display("FAIL wr_full_addr: got %h,%h want 8,9", we_addr[w0], we_addr[w0+1]); else pass_cnt++;
            total++; if (we_data[w0] !== 16'hBEEF || we_data[w0+1] !== 16'hDEAD)
                $display("FAIL wr_full_data: got %h,%h want beef,dead", we_data[w0], we_data[w0+1]); else pass_cnt++;
            total++; if (we_cyc[w0] !== t0 + 1 || we_cyc[w0+1] !== t0 + 4)
                $display("FAIL wr_full_we_pos: got %0d,%0d want %0d,%0d", we_cyc[w0] - t0, we_cyc[w0+1] - t0, 1, 4); else pass_cnt++;
            total++; if (we_be[w0] !== 2'b00 || we_be[w0+1] !== 2'b00)
                $display("FAIL wr_full_be: got %b,%b want 00,00", we_be[w0], we_be[w0+1]); else pass_cnt++;
        end
        total++; if (d !== 16'hFFFF) $display("FAIL wr_turnaround: got %h want ffff", d); else pass_cnt++;
    endtask

    task automatic test_read();
        int lat, t0, w0, o0;
        logic [31:0] got;
        logic [15:0] d;
        w0 = we_cyc.size(); o0 = oe_cnt;
        run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, got, t0, d);
        total++; if (lat !== 7) $display("FAIL rd_lat: got %0d want 7", lat); else pass_cnt++;
        total++; if (got !== ref_read(32'h10)) $display("FAIL rd_data: got %h want %h", got, ref_read(32'h10)); else pass_cnt++;
        total++; if (oe_cnt - o0 !== 6) $display("FAIL rd_oe_cycles: got %0d want 6", oe_cnt - o0); else pass_cnt++;
        total++; if (we_cyc.size() !== w0) $display("FAIL rd_no_we: got %0d want 0", we_cyc.size() - w0); else pass_cnt++;
    endtask

    task automatic test_partial_write();
        int lat, t0, w0;
        logic [31:0] got;
        logic [15:0] d;
        w0 = we_cyc.size();
        run_txn(1'b1, 32'h0000_0010, 32'h11223344, 4'b1000, lat, got, t0, d);
        model_write(32'h0000_0010, 32'h11223344, 4'b1000);
        total++; if (lat !== 4) $display("FAIL wr_part_lat: got %0d want 4", lat); else pass_cnt++;
        total++;
        if (we_cyc.size() - w0 !== 1) $display("FAIL wr_part_pulses: got %0d want 1", we_cyc.size() - w0);
        else if (we_addr[w0] !== 18'd9 || we_be[w0] !== 2'b01 || we_data[w0] !== 16'h1122 || we_cyc[w0] !== t0 + 1)
            $display("FAIL wr_part_beat: got a=%h be=%b d=%h c=%0d want a=9 be=01 d=1122 c=1",
                     we_addr[w0], we_be[w0], we_data[w0], we_cyc[w0] - t0);
        else pass_cnt++;
        run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, got, t0, d);
        total++; if (got !== 32'h11ADBEEF) $display("FAIL wr_part_readback: got %h want 11adbeef", got); else pass_cnt++;
        w0 = we_cyc.size();
        run_txn(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, lat, got, t0, d);
        total++; if (lat !== 1) $display("FAIL wr_mask0_lat: got %0d want 1", lat); else pass_cnt++;
        total++; if (we_cyc.size() !== w0) $display("FAIL wr_mask0_we: got %0d want 0", we_cyc.size() - w0); else pass_cnt++;
    endtask

    task automatic test_hold_request();
        int lat, t0;
        bit extra;
        logic [31:0] got;
        logic [15:0] d;
        repeat (2) @(negedge clk);
        req = 1'b1; rw = 1'b0; addr = 32'h0000_0010;
        lat = -1;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (i == 2) addr = 32'h0000_0400;
            if (ready) begin lat = i; break; end
        end
        total++; if (lat !== 7) $display("FAIL hold_lat: got %0d want 7", lat); else pass_cnt++;
        extra = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready || !ce_n) extra = 1'b1;
        end
        total++; if (extra !== 1'b0) $display("FAIL hold_no_restart: got %b want 0", extra); else pass_cnt++;
        req = 1'b0;
        run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, got, t0, d);
        total++; if (lat !== 7 || got !== ref_read(32'h10))
            $display("FAIL hold_next_txn: got %0d/%h want 7/%h", lat, got, ref_read(32'h10)); else pass_cnt++;
    endtask

    task automatic test_abort();
        int lat, t0, w0;
        bit extra;
        logic [31:0] got;
        logic [15:0] d;
        w0 = we_cyc.size();
        repeat (2) @(negedge clk);
        req = 1'b1; rw = 1'b1; addr = 32'h0000_0040; wdata = 32'h12345678; wmask = 4'hF;
        @(posedge clk);
        @(negedge clk);
        total++; if (ce_n !== 1'b0 || sd !== 16'h5678) $display("FAIL abort_beat0: got ce=%b d=%h want 0/5678", ce_n, sd); else pass_cnt++;
        req = 1'b0;
        @(negedge clk);
        total++; if (strobes !== 5'h1F) $display("FAIL abort_strobes: got %b want 11111", strobes); else pass_cnt++;
        total++; if (sd !== 16'hFFFF) $display("FAIL abort_bus: got %h want ffff", sd); else pass_cnt++;
        extra = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready) extra = 1'b1;
        end
        total++; if (extra !== 1'b0 || we_cyc.size() !== w0)
            $display("FAIL abort_quiet: got ready=%b we=%0d want 0/0", extra, we_cyc.size() - w0); else pass_cnt++;
        run_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, lat, got, t0, d);
        total++; if (got !== ref_read(32'h40)) $display("FAIL abort_mem: got %h want %h", got, ref_read(32'h40)); else pass_cnt++;
    endtask

    task automatic test_reset_mid_read();
        bit extra;
        repeat (2) @(negedge clk);
        req = 1'b1; rw = 1'b0; addr = 32'h0000_0014;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (strobes !== 5'h1F || sa !== 18'h0)
            $display("FAIL rst_mid_pins: got %b/%h want 11111/0", strobes, sa); else pass_cnt++;
        total++; if (rdata !== 32'h0 || ready !== 1'b0)
            $display("FAIL rst_mid_bus: got %h/%b want 0/0", rdata, ready); else pass_cnt++;
        @(negedge clk);
        req = 1'b0; rst_n = 1'b1;
        extra = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready || !ce_n) extra = 1'b1;
        end
        total++; if (extra !== 1'b0) $display("FAIL rst_mid_quiet: got %b want 0", extra); else pass_cnt++;
    endtask

    task automatic test_wrap();
        int lat, t0, w0;
        logic [31:0] got;
        logic [15:0] d;
        w0 = we_cyc.size();
        run_txn(1'b1, 32'hFFFF_FFFC, 32'hCAFEF00D, 4'hF, lat, got, t0, d);
        model_write(32'hFFFF_FFFC, 32'hCAFEF00D, 4'hF);
        total++;
        if (we_cyc.size() - w0 !== 2) $display("FAIL wrap_pulses: got %0d want 2", we_cyc.size() - w0);
        else if (we_addr[w0] !== 18'h3FFFE || we_addr[w0+1] !== 18'h3FFFF)
            $display("FAIL wrap_addr: got %h,%h want 3fffe,3ffff", we_addr[w0], we_addr[w0+1]);
        else pass_cnt++;
        run_txn(1'b0, 32'h0007_FFFC, 32'h0, 4'h0, lat, got, t0, d);
        total++; if (got !== 32'hCAFEF00D) $display("FAIL wrap_alias: got %h want cafef00d", got); else pass_cnt++;
    endtask

    task automatic test_random();
        int lat, t0, w0, k;
        bit ok;
        logic t_rw;
        logic [31:0] t_addr, t_wdata, got, expd;
        logic [3:0] t_mask;
        logic [15:0] d;
        for (int n = 0; n < 40; n++) begin
            t_rw    = 1'($urandom_range(0, 1));
            t_addr  = ($urandom & 32'hFFF8_0000) | (32'($urandom_range(0, 15)) << 2);
            t_wdata = $urandom;
            t_mask  = 4'($urandom);
            expd    = ref_read(t_addr);
            w0      = we_cyc.size();
            run_txn(t_rw, t_addr, t_wdata, t_mask, lat, got, t0, d);
            total++; if (lat !== exp_lat(t_rw, t_mask, 3))
                $display("FAIL rand_lat[%0d]: got %0d want %0d", n, lat, exp_lat(t_rw, t_mask, 3)); else pass_cnt++;
            total++;
            if (!t_rw) begin
                if (got !== expd) $display("FAIL rand_rdata[%0d]: got %h want %h", n, got, expd); else pass_cnt++;
            end else begin
                ok = (we_cyc.size() - w0 == (exp_lat(1'b1, t_mask, 3) - 1) / 3);
                k = w0;
                for (int b = 0; b < 2 && ok; b++) begin
                    if (t_mask[2*b +: 2] != 2'b00) begin
                        if (we_addr[k] !== 18'(hw(t_addr, b)) || we_data[k] !== t_wdata[16*b +: 16]) ok = 1'b0;
                        k++;
                    end
                end
                if (!ok) $display("FAIL rand_write[%0d]: got %0d pulses want mask %b at %h", n, we_cyc.size() - w0, t_mask, t_addr);
                else pass_cnt++;
                model_write(t_addr, t_wdata, t_mask);
            end
        end
    endtask

    task automatic test_access5();
        int lat;
        logic [31:0] a5, expd, h;
        for (int n = 0; n < 3; n++) begin
            a5 = (n == 0) ? 32'h0000_0104 : $urandom;
            h = hw(a5, 0); expd[15:0]  = h[15:0] ^ 16'h5A3C;
            h = hw(a5, 1); expd[31:16] = h[15:0] ^ 16'h5A3C;
            repeat (2) @(negedge clk);
            req5 = 1'b1; rw = 1'b0; addr = a5;
            @(posedge clk);
            lat = -1;
            for (int i = 1; i <= 64; i++) begin
                @(negedge clk);
                if (ready5) begin lat = i; break; end
            end
            total++; if (lat !== 11) $display("FAIL ac5_lat[%0d]: got %0d want 11", n, lat); else pass_cnt++;
            total++; if (rdata5 !== expd) $display("FAIL ac5_rdata[%0d]: got %h want %h", n, rdata5, expd); else pass_cnt++;
            req5 = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
        #1 rst_n = 1'b0;
        #2 test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_write_full();
        test_read();
        test_partial_write();
        test_hold_request();
        test_abort();
        test_reset_mid_read();
        test_wrap();
        test_random();
        test_access5();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
